// File: rtl/ltc2145_axil_regs.sv
// AXI4-Lite slave register file for the LTC2145 capture path.
//   ACLK / ARESET   : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B* : write address, data and response channels
//   S_AXI_AR*/R*    : read address and data channels
//   REG_OUT         : {reg3, reg2, reg1, reg0} straight from the register flops
// Map (word index = ADDR[4:2]): 0..3 reg0..reg3 RW, 4 ID (RO), 5..7 unmapped.
module ltc2145_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_ID_VALUE = 32'h2145_0100
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] REG_OUT
);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  // init_q keeps all readies low while reset is held and for the first edge after.
  logic                          init_q;
  logic                          aw_full;
  logic [2:0]                    aw_idx;
  logic                          w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [NBYTES-1:0]             w_strb_q;
  logic                          bvalid_q;
  resp_e                         bresp_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  resp_e                         rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic                          aw_hs, w_hs, ar_hs, commit;
  logic [2:0]                    ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_n;
  resp_e                         rd_resp_n;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = init_q && !aw_full;
  assign S_AXI_WREADY  = init_q && !w_full;
  assign S_AXI_ARREADY = init_q && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign REG_OUT       = {regs[3], regs[2], regs[1], regs[0]};

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  // Commit waits for the previous response to drain: one write outstanding.
  assign commit = aw_full && w_full && !bvalid_q;
  assign ar_idx = S_AXI_ARADDR[4:2];

  // Write capture and response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q   <= 1'b0;
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      init_q <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= aw_idx[2] ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register array, byte-wise update on commit to indices 0..3
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit && !aw_idx[2]) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (w_strb_q[b]) regs[aw_idx[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  // Read decode from current flop state, so a same-edge write is not yet visible.
  always_comb begin
    rd_data_n = '0;
    rd_resp_n = RESP_OKAY;
    case (ar_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data_n = regs[ar_idx[1:0]];
      3'd4:                   rd_data_n = C_ID_VALUE;
      default:                rd_resp_n = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_n;
      rresp_q  <= rd_resp_n;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule
